// File: rtl/serial_link_pkg.sv
// Constants and types shared by both ends of the header/data/footer serial link.
package serial_link_pkg;

  localparam logic [3:0] HEADER   = 4'b1010;
  localparam logic [3:0] FOOTER   = 4'b0111;
  localparam int         MAX_BITS = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HEAD = 2'd1,
    DATA = 2'd2,
    FOOT = 2'd3
  } state_t;

  // A length field of 0 stands for a full 32-bit word.
  function automatic logic [5:0] len_to_n(input logic [4:0] length);
    return (length == 5'd0) ? 6'(MAX_BITS) : {1'b0, length};
  endfunction

endpackage

// File: rtl/serial_bit_timer.sv
// Divides clk_i into serial_clk bit periods: CLK_DIV cycles low, then CLK_DIV cycles high.
module serial_bit_timer #(
  parameter int CLK_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en,
  output logic serial_clk,
  output logic bit_start,
  output logic bit_end
);

  localparam int                CNT_W   = $clog2(2 * CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_RISE = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2 * CLK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt        <= '0;
      serial_clk <= 1'b0;
    end else if (!en) begin
      cnt        <= '0;
      serial_clk <= 1'b0;
    end else if (cnt == CNT_LAST) begin
      cnt        <= '0;
      serial_clk <= 1'b0;
    end else begin
      cnt <= cnt + 1'b1;
      if (cnt == CNT_RISE) serial_clk <= 1'b1;
    end
  end

  // The edge that closes a bit's high phase is the edge that opens the next low phase.
  assign bit_end   = en && (cnt == CNT_LAST);
  assign bit_start = bit_end;

endmodule

// File: rtl/serial_tx.sv
// Frame transmitter: sends header 1010, N data bits MSB-first, footer 0111 on a generated serial clock.
module serial_tx
  import serial_link_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] dat_i,
  input  logic [4:0]  length_i,
  input  logic        valid_i,
  output logic        ready_o,
  output logic        serial_clk,
  output logic        serial_o,
  output logic        busy_o,
  output logic        done_o
);

  state_t      state;
  logic [4:0]  bit_cnt;
  logic [5:0]  n_reg;
  logic [31:0] dat_reg;
  logic [4:0]  n_last;
  logic [1:0]  nib_idx;
  logic        next_bit;
  logic        bit_start;
  logic        bit_end;

  serial_bit_timer #(
    .CLK_DIV(CLK_DIV)
  ) u_timer (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .en        (busy_o),
    .serial_clk(serial_clk),
    .bit_start (bit_start),
    .bit_end   (bit_end)
  );

  assign n_last = 5'(n_reg - 6'd1);

  // Value serial_o takes when the next bit period opens.
  always_comb begin
    nib_idx  = bit_cnt[1:0] - 2'd1;
    next_bit = 1'b0;
    case (state)
      HEAD:    next_bit = (bit_cnt == 5'd0) ? dat_reg[n_last] : HEADER[nib_idx];
      DATA:    next_bit = (bit_cnt == 5'd0) ? FOOTER[3] : dat_reg[bit_cnt - 5'd1];
      FOOT:    next_bit = (bit_cnt == 5'd0) ? 1'b0 : FOOTER[nib_idx];
      default: next_bit = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      n_reg    <= '0;
      dat_reg  <= '0;
      serial_o <= 1'b0;
      busy_o   <= 1'b0;
      ready_o  <= 1'b1;
      done_o   <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (valid_i && ready_o) begin
            dat_reg  <= dat_i;
            n_reg    <= len_to_n(length_i);
            bit_cnt  <= 5'd3;
            serial_o <= HEADER[3];
            busy_o   <= 1'b1;
            ready_o  <= 1'b0;
            state    <= HEAD;
          end
        end
        HEAD, DATA, FOOT: begin
          if (bit_start) serial_o <= next_bit;
          if (bit_end) begin
            if (bit_cnt != 5'd0) begin
              bit_cnt <= bit_cnt - 5'd1;
            end else if (state == HEAD) begin
              bit_cnt <= n_last;
              state   <= DATA;
            end else if (state == DATA) begin
              bit_cnt <= 5'd3;
              state   <= FOOT;
            end else begin
              busy_o  <= 1'b0;
              ready_o <= 1'b1;
              done_o  <= 1'b1;
              state   <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx: frames captured on serial_clk rising edges and checked against hand-built vectors.
module tb_serial_tx;

  localparam int CLK_DIV = 4;

  logic        clk_i    = 1'b0;
  logic        rst_i    = 1'b0;
  logic [31:0] dat_i    = '0;
  logic [4:0]  length_i = '0;
  logic        valid_i  = 1'b0;
  logic        ready_o;
  logic        serial_clk;
  logic        serial_o;
  logic        busy_o;
  logic        done_o;

  serial_tx #(
    .CLK_DIV(CLK_DIV)
  ) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .dat_i     (dat_i),
    .length_i  (length_i),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .serial_clk(serial_clk),
    .serial_o  (serial_o),
    .busy_o    (busy_o),
    .done_o    (done_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Line monitor: collects bits on serial_clk rising edges, closes a frame on done_o.
  typedef struct {
    logic [63:0] bits;
    int          n;
    int          cyc;
    int          gap;
  } frame_t;

  frame_t      frames[$];
  logic [63:0] cap_bits  = '0;
  int          cap_n     = 0;
  int          cyc       = 0;
  int          low_run   = 0;
  int          first_gap = 0;
  int          so_viol   = 0;
  logic        sclk_prev = 1'b0;
  logic        so_prev   = 1'b0;
  logic        busy_prev = 1'b0;

  always @(posedge clk_i) begin
    #1;
    if (!rst_i) begin
      cap_bits  = '0;
      cap_n     = 0;
      cyc       = 0;
      low_run   = 0;
      first_gap = 0;
    end else begin
      if (serial_o !== so_prev && !(sclk_prev && !serial_clk) && !(busy_o && !busy_prev))
        so_viol++;
      if (busy_o && !busy_prev) cyc = 0;
      else cyc++;
      if (serial_clk && !sclk_prev) begin
        if (cap_n == 0) first_gap = low_run;
        cap_bits = {cap_bits[62:0], serial_o};
        cap_n++;
      end
      low_run = serial_clk ? 0 : low_run + 1;
      if (done_o) begin
        frames.push_back('{cap_bits, cap_n, cyc, first_gap});
        cap_bits  = '0;
        cap_n     = 0;
        first_gap = 0;
      end
    end
    sclk_prev = serial_clk;
    so_prev   = serial_o;
    busy_prev = busy_o;
  end

  task automatic wait_ready(input string tag);
    int w = 0;
    while (!ready_o && w < 2000) begin
      @(negedge clk_i);
      w++;
    end
    check({tag, " ready seen"}, 64'(w < 2000), 64'd1);
  endtask

  task automatic send(input logic [31:0] d, input logic [4:0] l, input string tag);
    @(negedge clk_i);
    dat_i    = d;
    length_i = l;
    valid_i  = 1'b1;
    wait_ready(tag);
    @(posedge clk_i);
    #1;
    valid_i = 1'b0;
    check({tag, " busy,ready after accept"}, {62'd0, busy_o, ready_o}, 64'b10);
  endtask

  task automatic wait_frames(input int k, input string tag);
    int w = 0;
    while (frames.size() < k && w < 3000) begin
      @(negedge clk_i);
      w++;
    end
    check({tag, " frame count"}, 64'(frames.size() >= k), 64'd1);
  endtask

  task automatic check_frame(input string tag, input logic [63:0] eb, input int en,
                             input logic [4:0] l, output int gap);
    frame_t f;
    int     nn;
    gap = -1;
    if (frames.size() == 0) return;
    f   = frames.pop_front();
    nn  = (l == 5'd0) ? 32 : int'(l);
    gap = f.gap;
    check({tag, " bits"}, f.bits, eb);
    check({tag, " bit count"}, 64'(f.n), 64'(en));
    check({tag, " done latency"}, 64'(f.cyc), 64'((nn + 8) * 2 * CLK_DIV));
  endtask

  typedef struct {
    logic [31:0] dat;
    logic [4:0]  len;
    logic [63:0] exp_bits;
    int          exp_n;
    string       name;
  } vec_t;

  vec_t vecs[3];

  initial begin
    int bad_idle;
    int g;

    vecs[0] = '{32'h0000_00A5, 5'd8, 64'hAA57,       16, "a5_len8"};
    vecs[1] = '{32'h8000_0001, 5'd0, 64'hA8_0000_0017, 40, "len32"};
    vecs[2] = '{32'hFFFF_FFFE, 5'd1, 64'h147,        9,  "len1"};

    // Reset state
    repeat (3) @(negedge clk_i);
    check("reset outputs clk,so,busy,done,ready",
          {59'd0, serial_clk, serial_o, busy_o, done_o, ready_o}, 64'b00001);
    rst_i = 1'b1;

    bad_idle = 0;
    repeat (20) begin
      @(negedge clk_i);
      if ({serial_clk, serial_o, busy_o, done_o, ready_o} !== 5'b00001) bad_idle++;
    end
    check("idle line stays quiet", 64'(bad_idle), 64'd0);

    for (int i = 0; i < 3; i++) begin
      send(vecs[i].dat, vecs[i].len, vecs[i].name);
      wait_frames(1, vecs[i].name);
      check_frame(vecs[i].name, vecs[i].exp_bits, vecs[i].exp_n, vecs[i].len, g);
      repeat (5) @(negedge clk_i);
    end

    // Back-to-back: valid held high, B must go in A's done cycle
    @(negedge clk_i);
    dat_i    = 32'h0000_003C;
    length_i = 5'd6;
    valid_i  = 1'b1;
    wait_ready("b2b_a");
    @(posedge clk_i);
    #1;
    check("b2b_a busy,ready after accept", {62'd0, busy_o, ready_o}, 64'b10);
    dat_i    = 32'h0000_0015;
    length_i = 5'd5;
    @(negedge clk_i);
    wait_ready("b2b_b");
    check("b2b_b accepted in done cycle", 64'(done_o), 64'd1);
    @(posedge clk_i);
    #1;
    valid_i = 1'b0;
    check("b2b_b busy,ready after accept", {62'd0, busy_o, ready_o}, 64'b10);
    wait_frames(2, "b2b");
    check_frame("b2b_a", 64'h2BC7, 14, 5'd6, g);
    check_frame("b2b_b", 64'h1557, 13, 5'd5, g);
    check("b2b low gap", 64'(g), 64'(CLK_DIV + 1));
    repeat (5) @(negedge clk_i);

    // Asynchronous reset in the middle of the data field
    send(32'h0000_00A5, 5'd8, "abort");
    repeat (40) @(posedge clk_i);
    #3;
    rst_i    = 1'b0;
    valid_i  = 1'b1;
    dat_i    = 32'h0000_003C;
    length_i = 5'd6;
    #1;
    check("async reset outputs clk,so,busy,done,ready",
          {59'd0, serial_clk, serial_o, busy_o, done_o, ready_o}, 64'b00001);
    repeat (3) @(negedge clk_i);
    check("reset held with valid high", {59'd0, serial_clk, serial_o, busy_o, done_o, ready_o},
          64'b00001);
    check("aborted frame not reported", 64'(frames.size()), 64'd0);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    valid_i = 1'b0;
    check("post-reset busy,ready after accept", {62'd0, busy_o, ready_o}, 64'b10);
    wait_frames(1, "post_reset");
    check_frame("post_reset", 64'h2BC7, 14, 5'd6, g);

    repeat (5) @(negedge clk_i);
    check("serial_o changes only at bit start", 64'(so_viol), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
